// File: rtl/extremum_finder.sv
// Scans the first `count` words of a synchronous-read memory and reports the
// largest (mode=0) or smallest (mode=1) value plus the lowest index holding it.
// The memory returns M[addr] one cycle after addr is presented, so a priming
// cycle precedes the one-word-per-cycle scan.
module extremum_finder #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [ADDR_W-1:0] result_idx,
    output logic              empty
);

    localparam logic [ADDR_W:0]   DEPTH    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   K_ONE    = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        SCAN,
        DONE
    } state_t;

    state_t              state;
    logic                mode_q;
    logic [ADDR_W:0]     count_q;
    logic [ADDR_W:0]     k;
    logic [DATA_W-1:0]   acc;
    logic [ADDR_W-1:0]   acc_idx;

    logic [ADDR_W:0]     count_clamped;
    logic                greater;
    logic                less;
    logic                take;
    logic                last;
    logic [DATA_W-1:0]   next_acc;
    logic [ADDR_W-1:0]   next_idx;
    logic [ADDR_W-1:0]   next_addr;

    // Clamp oversized requests to the memory depth so the scan never wraps.
    always_comb begin
        count_clamped = (count > DEPTH) ? DEPTH : count;
    end

    // Decide whether the word arriving this cycle replaces the running extreme.
    always_comb begin
        greater = 1'b0;
        less    = 1'b0;
        if (SIGNED != 0) begin
            greater = $signed(mem_data) > $signed(acc);
            less    = $signed(mem_data) < $signed(acc);
        end else begin
            greater = mem_data > acc;
            less    = mem_data < acc;
        end
        take      = (k == '0) || (mode_q ? less : greater);
        next_acc  = take ? mem_data : acc;
        next_idx  = take ? k[ADDR_W-1:0] : acc_idx;
        last      = (k == (count_q - K_ONE));
        next_addr = (mem_addr == ADDR_MAX) ? mem_addr : (mem_addr + ADDR_ONE);
    end

    // Control FSM with registered handshake, address and result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            mem_addr   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            result_idx <= '0;
            empty      <= 1'b0;
            mode_q     <= 1'b0;
            count_q    <= '0;
            k          <= '0;
            acc        <= '0;
            acc_idx    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    mem_addr <= '0;
                    done     <= 1'b0;
                    if (start) begin
                        mode_q  <= mode;
                        count_q <= count_clamped;
                        k       <= '0;
                        busy    <= 1'b1;
                        state   <= PRIME;
                    end
                end
                PRIME: begin
                    if (count_q == '0) begin
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        empty      <= 1'b1;
                        result     <= '0;
                        result_idx <= '0;
                        mem_addr   <= '0;
                        state      <= DONE;
                    end else begin
                        mem_addr <= ADDR_ONE;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    acc      <= next_acc;
                    acc_idx  <= next_idx;
                    k        <= k + K_ONE;
                    mem_addr <= next_addr;
                    if (last) begin
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        empty      <= 1'b0;
                        result     <= next_acc;
                        result_idx <= next_idx;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    done     <= 1'b0;
                    mem_addr <= '0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_extremum_finder.sv
// Bench for extremum_finder: an unsigned 8-bit instance and a signed 4-bit
// instance, each attached to its own synchronous-read memory model.
module tb_extremum_finder;

    logic clk;
    logic reset;

    logic       start_u, mode_u;
    logic [4:0] count_u;
    logic [3:0] addr_u;
    logic [7:0] data_u;
    logic       busy_u, done_u, empty_u;
    logic [7:0] result_u;
    logic [3:0] idx_u;

    logic       start_s, mode_s;
    logic [4:0] count_s;
    logic [3:0] addr_s;
    logic [3:0] data_s;
    logic       busy_s, done_s, empty_s;
    logic [3:0] result_s;
    logic [3:0] idx_s;

    logic [7:0] mem_u [16];
    logic [3:0] mem_s [16];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       mode;
        logic [4:0] count;
        logic [7:0] res;
        logic [3:0] idx;
        logic       emp;
        int         edge_n;
    } vec_t;

    vec_t tbl [8];

    extremum_finder #(.DATA_W(8), .ADDR_W(4), .SIGNED(0)) dut (
        .clk(clk), .reset(reset), .start(start_u), .mode(mode_u), .count(count_u),
        .mem_addr(addr_u), .mem_data(data_u), .busy(busy_u), .done(done_u),
        .result(result_u), .result_idx(idx_u), .empty(empty_u)
    );

    extremum_finder #(.DATA_W(4), .ADDR_W(4), .SIGNED(1)) dut_s (
        .clk(clk), .reset(reset), .start(start_s), .mode(mode_s), .count(count_s),
        .mem_addr(addr_s), .mem_data(data_s), .busy(busy_s), .done(done_s),
        .result(result_s), .result_idx(idx_s), .empty(empty_s)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models with one cycle of registered read latency.
    always @(posedge clk) begin
        data_u <= mem_u[addr_u];
        data_s <= mem_s[addr_s];
    end

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Reference: plain search over the first min(count,16) words, strict
    // comparison so the earliest occurrence wins.
    function automatic void model_u(input logic m, input logic [4:0] c, output logic [7:0] r,
                                    output logic [3:0] i, output logic e, output int ed);
        int n;
        n = (c > 16) ? 16 : int'(c);
        r = 8'd0;
        i = 4'd0;
        e = (n == 0);
        ed = (n == 0) ? 1 : n + 1;
        if (n > 0) begin
            r = mem_u[0];
            for (int j = 1; j < n; j++) begin
                if (m ? (mem_u[j] < r) : (mem_u[j] > r)) begin
                    r = mem_u[j];
                    i = 4'(j);
                end
            end
        end
    endfunction

    task automatic load_table_memory();
        for (int j = 0; j < 16; j++) mem_u[j] = 8'd0;
        mem_u[0] = 8'd3;
        mem_u[1] = 8'd9;
        mem_u[2] = 8'd1;
        mem_u[3] = 8'd9;
    endtask

    // Launch one scan, scramble mode/count while busy, and wait for done.
    task automatic apply_stimulus(input bit sel, input logic m, input logic [4:0] c,
                                  output int edge_n, output logic [7:0] res,
                                  output logic [3:0] idx, output logic emp);
        @(negedge clk);
        if (sel) begin
            start_s = 1'b1; mode_s = m; count_s = c;
        end else begin
            start_u = 1'b1; mode_u = m; count_u = c;
        end
        @(posedge clk);
        #1;
        start_u = 1'b0;
        start_s = 1'b0;
        mode_u = ~m; count_u = 5'd1;
        mode_s = ~m; count_s = 5'd1;
        check("busy_after_start", 32'(sel ? busy_s : busy_u), 32'd1);
        edge_n = -1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if ((sel ? done_s : done_u) == 1'b1) begin
                edge_n = e;
                break;
            end
        end
        res = sel ? {4'b0, result_s} : result_u;
        idx = sel ? idx_s : idx_u;
        emp = sel ? empty_s : empty_u;
        check("busy_at_done", 32'(sel ? busy_s : busy_u), 32'd0);
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(sel ? done_s : done_u), 32'd0);
    endtask

    task automatic check_output(input string tag, input int edge_n, input logic [7:0] res,
                                input logic [3:0] idx, input logic emp, input int exp_edge,
                                input logic [7:0] exp_res, input logic [3:0] exp_idx,
                                input logic exp_emp);
        check({tag, "_edge"}, 32'(edge_n), 32'(exp_edge));
        check({tag, "_result"}, 32'(res), 32'(exp_res));
        check({tag, "_idx"}, 32'(idx), 32'(exp_idx));
        check({tag, "_empty"}, 32'(emp), 32'(exp_emp));
    endtask

    initial begin
        int         ed;
        int         exp_ed;
        int         dones;
        logic [7:0] r, exp_r;
        logic [3:0] i, exp_i;
        logic       e, exp_e;

        tbl[0] = '{1'b0, 5'd16, 8'd9, 4'd1, 1'b0, 17};
        tbl[1] = '{1'b1, 5'd4,  8'd1, 4'd2, 1'b0, 5};
        tbl[2] = '{1'b0, 5'd1,  8'd3, 4'd0, 1'b0, 2};
        tbl[3] = '{1'b1, 5'd16, 8'd0, 4'd4, 1'b0, 17};
        tbl[4] = '{1'b0, 5'd2,  8'd9, 4'd1, 1'b0, 3};
        tbl[5] = '{1'b1, 5'd3,  8'd1, 4'd2, 1'b0, 4};
        tbl[6] = '{1'b0, 5'd0,  8'd0, 4'd0, 1'b1, 1};
        tbl[7] = '{1'b1, 5'd31, 8'd0, 4'd4, 1'b0, 17};

        reset = 1'b1;
        start_u = 1'b0; mode_u = 1'b0; count_u = '0;
        start_s = 1'b0; mode_s = 1'b0; count_s = '0;
        load_table_memory();
        for (int j = 0; j < 16; j++) mem_s[j] = 4'h0;
        mem_s[0] = 4'h7;
        mem_s[1] = 4'h8;
        mem_s[2] = 4'h2;

        #2;
        check("rst_result", 32'(result_u), 32'd0);
        check("rst_idx", 32'(idx_u), 32'd0);
        check("rst_busy_done_empty", {29'd0, busy_u, done_u, empty_u}, 32'd0);
        check("rst_addr", 32'(addr_u), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Table-driven scans over M = {3,9,1,9,0,...}.
        for (int t = 0; t < 8; t++) begin
            apply_stimulus(1'b0, tbl[t].mode, tbl[t].count, ed, r, i, e);
            check_output($sformatf("tbl%0d", t), ed, r, i, e,
                         tbl[t].edge_n, tbl[t].res, tbl[t].idx, tbl[t].emp);
        end

        // Signed instance: 4'h8 is -8, so max is 7 and min is -8.
        apply_stimulus(1'b1, 1'b0, 5'd3, ed, r, i, e);
        check_output("signed_max", ed, r, i, e, 4, 8'h07, 4'd0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 5'd3, ed, r, i, e);
        check_output("signed_min", ed, r, i, e, 4, 8'h08, 4'd1, 1'b0);

        // Clamped count over an all-FF memory: ties keep index 0.
        for (int j = 0; j < 16; j++) mem_u[j] = 8'hFF;
        apply_stimulus(1'b0, 1'b0, 5'd31, ed, r, i, e);
        check_output("all_ff", ed, r, i, e, 17, 8'hFF, 4'd0, 1'b0);

        // Start held high while busy must yield exactly one done.
        load_table_memory();
        @(negedge clk);
        start_u = 1'b1; mode_u = 1'b0; count_u = 5'd4;
        repeat (4) @(posedge clk);
        @(negedge clk);
        start_u = 1'b0;
        dones = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            if (done_u) dones++;
        end
        check("held_start_dones", 32'(dones), 32'd1);
        check("held_start_result", 32'(result_u), 32'd9);
        check("held_start_idx", 32'(idx_u), 32'd1);

        // Start raised during the done cycle is ignored.
        @(negedge clk);
        start_u = 1'b1; mode_u = 1'b1; count_u = 5'd2;
        @(posedge clk);
        #1;
        start_u = 1'b0;
        dones = 0;
        for (int c = 0; c < 20 && dones == 0; c++) begin
            @(posedge clk);
            #1;
            if (done_u) dones = 1;
        end
        check("done_cycle_first_done", 32'(dones), 32'd1);
        start_u = 1'b1;
        @(posedge clk);
        #1;
        check("start_in_done_ignored", 32'(busy_u), 32'd0);
        start_u = 1'b0;
        @(posedge clk);
        #1;
        check("start_in_done_still_idle", 32'(busy_u), 32'd0);

        // Reset at E5 of a 16-word scan aborts with no done pulse.
        apply_stimulus(1'b0, 1'b0, 5'd16, ed, r, i, e);
        check_output("pre_reset", ed, r, i, e, 17, 8'd9, 4'd1, 1'b0);
        @(negedge clk);
        start_u = 1'b1; mode_u = 1'b0; count_u = 5'd16;
        @(posedge clk);
        #1;
        start_u = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_result", 32'(result_u), 32'd0);
        check("midrst_idx", 32'(idx_u), 32'd0);
        check("midrst_busy_done", {30'd0, busy_u, done_u}, 32'd0);
        check("midrst_addr", 32'(addr_u), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done_u) dones++;
        end
        check("midrst_no_done", 32'(dones), 32'd0);
        apply_stimulus(1'b0, 1'b0, 5'd16, ed, r, i, e);
        check_output("post_reset", ed, r, i, e, 17, 8'd9, 4'd1, 1'b0);

        // Randomized scans against the reference model; odd rounds force ties.
        for (int n = 0; n < 24; n++) begin
            logic       m;
            logic [4:0] c;
            for (int j = 0; j < 16; j++)
                mem_u[j] = 8'($urandom_range(0, (n % 2 == 1) ? 3 : 255));
            m = 1'($urandom_range(0, 1));
            c = 5'($urandom_range(0, 31));
            model_u(m, c, exp_r, exp_i, exp_e, exp_ed);
            apply_stimulus(1'b0, m, c, ed, r, i, e);
            check_output($sformatf("rand%0d", n), ed, r, i, e, exp_ed, exp_r, exp_i, exp_e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
